// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit with architectural HI/LO
// registers. One multiply or divide step per cycle; the result is sign-corrected
// and written to HI/LO in a final cycle, followed by a one-cycle done pulse.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]        cnt;
    logic                 is_div;
    logic                 b_zero;
    logic                 neg_main;
    logic                 neg_rem;
    logic [WIDTH-1:0]     opnd;
    logic [WIDTH-1:0]     a_raw;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quo;

    logic                 accept_md;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign busy = (state != IDLE);

    // Operand magnitudes and single-step arithmetic for both iterative datapaths
    always_comb begin
        accept_md = start && (state == IDLE) && !op[2];
        a_mag     = (op[0] && a[WIDTH-1]) ? -a : a;
        b_mag     = (op[0] && b[WIDTH-1]) ? -b : b;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {rem, quo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        prod_fix  = neg_main ? -acc : acc;
        quo_fix   = neg_main ? -quo : quo;
        rem_fix   = neg_rem ? -rem : rem;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN on an accepted mul/div, WIDTH steps, then FIN
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_md) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, result write-back and direct HI/LO moves
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            b_zero   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            opnd     <= '0;
            a_raw    <= '0;
            acc      <= '0;
            rem      <= '0;
            quo      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                cnt      <= '0;
                                is_div   <= op[1];
                                b_zero   <= (b == '0);
                                neg_main <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_rem  <= op[0] & a[WIDTH-1];
                                a_raw    <= a;
                                if (op[1]) begin
                                    opnd <= b_mag;
                                    quo  <= a_mag;
                                    rem  <= '0;
                                end else begin
                                    opnd <= a_mag;
                                    acc  <= {{WIDTH{1'b0}}, b_mag};
                                end
                            end
                            3'b100:  hi <= a;
                            3'b101:  lo <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        rem <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                end
                FIN: begin
                    done <= 1'b1;
                    if (!is_div) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (b_zero) begin
                        hi <= a_raw;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized self-checking bench for muldiv_unit (WIDTH=32 and WIDTH=8)
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        rst8, start8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    int checks = 0;
    int passes = 0;
    longint unsigned mHi = 0, mLo = 0, mHi8 = 0, mLo8 = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    // Compare one observed value against its expectation and tally the result
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Architectural reference: plain integer arithmetic on w-bit operands
    function automatic void refModel(input int w, input logic [2:0] o,
                                     input longint unsigned xin, input longint unsigned yin,
                                     inout longint unsigned rh, inout longint unsigned rl);
        longint unsigned mask, x, y, p;
        longint sx, sy, q, r;
        mask = (64'd1 << w) - 64'd1;
        x = xin & mask;
        y = yin & mask;
        sx = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
        sy = y[w-1] ? longint'(y) - (longint'(1) << w) : longint'(y);
        case (o)
            3'd0: begin p = x * y; rh = (p >> w) & mask; rl = p & mask; end
            3'd1: begin p = longint'(sx * sy); rh = (p >> w) & mask; rl = p & mask; end
            3'd2, 3'd3: begin
                if (y == 0) begin
                    rl = mask; rh = x;
                end else if (o == 3'd2) begin
                    rl = x / y; rh = x % y;
                end else begin
                    q = sx / sy; r = sx % sy;
                    rl = longint'(q) & mask; rh = longint'(r) & mask;
                end
            end
            3'd4: rh = x;
            3'd5: rl = x;
            default: ;
        endcase
    endfunction

    // Operand source biased toward corner values
    function automatic logic [31:0] pickOperand(input int w);
        logic [31:0] m, v;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = m;
            2: v = 32'd1 << (w - 1);
            3: v = 32'd1;
            default: v = $urandom;
        endcase
        return v & m;
    endfunction

    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
    endtask

    // Issue one WIDTH=32 operation at the current negedge and check it through completion
    task automatic runOp32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           input bit chain, input bit junk);
        int k;
        applyStimulus(o, x, y);
        refModel(32, o, x, y, mHi, mLo);
        @(negedge clk);
        start = 1'b0;
        if (!o[2]) begin
            k = 0;
            while (!done && k < 42) begin
                checkOutput("busy_run", 64'(busy), 64'd1);
                if (junk && k == 5) applyStimulus(3'($urandom_range(0, 7)), $urandom, $urandom);
                if (junk && k == 6) start = 1'b0;
                @(negedge clk);
                k++;
            end
            checkOutput("latency", 64'(k), 64'd33);
            checkOutput("busy_at_done", 64'(busy), 64'd0);
        end else begin
            checkOutput("busy_move", 64'(busy), 64'd0);
            checkOutput("done_move", 64'(done), 64'd0);
        end
        checkOutput("hi", 64'(hi), mHi);
        checkOutput("lo", 64'(lo), mLo);
        if (!chain) begin
            @(negedge clk);
            checkOutput("done_one_cycle", 64'(done), 64'd0);
            checkOutput("hi_hold", 64'(hi), mHi);
            checkOutput("lo_hold", 64'(lo), mLo);
        end
    endtask

    // Issue one WIDTH=8 operation and check result and latency
    task automatic runOp8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        int k;
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        refModel(8, o, 64'(x), 64'(y), mHi8, mLo8);
        @(negedge clk);
        start8 = 1'b0;
        if (!o[2]) begin
            k = 0;
            while (!done8 && k < 20) begin
                @(negedge clk);
                k++;
            end
            checkOutput("latency8", 64'(k), 64'd9);
        end
        checkOutput("hi8", 64'(hi8), mHi8);
        checkOutput("lo8", 64'(lo8), mLo8);
        @(negedge clk);
        checkOutput("done8_one_cycle", 64'(done8), 64'd0);
    endtask

    initial begin
        bit sawDone;
        rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        rst8 = 1'b1; start8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0; rst8 = 1'b0;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_hi", 64'(hi), 64'd0);
        checkOutput("rst_lo", 64'(lo), 64'd0);

        runOp32(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        checkOutput("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
        checkOutput("multu_max_lo", 64'(lo), 64'h0000_0001);
        checkOutput("multu_done", 64'(done), 64'd1);
        @(negedge clk);
        checkOutput("multu_done_drop", 64'(done), 64'd0);

        runOp32(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        runOp32(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        checkOutput("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
        checkOutput("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
        runOp32(3'd2, 32'd100, 32'd7, 1'b0, 1'b0);
        runOp32(3'd2, 32'd7, 32'd0, 1'b0, 1'b0);
        checkOutput("divz_lo", 64'(lo), 64'hFFFF_FFFF);
        checkOutput("divz_hi", 64'(hi), 64'd7);
        runOp32(3'd3, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0);
        runOp32(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        checkOutput("div_ovf_lo", 64'(lo), 64'h8000_0000);
        checkOutput("div_ovf_hi", 64'(hi), 64'd0);

        runOp32(3'd4, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        checkOutput("mthi_val", 64'(hi), 64'h1234);
        runOp32(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
        runOp32(3'd6, 32'h1111_1111, 32'd3, 1'b0, 1'b0);
        runOp32(3'd7, 32'h2222_2222, 32'd3, 1'b0, 1'b0);

        runOp32(3'd2, 32'd1000, 32'd9, 1'b0, 1'b1);
        runOp32(3'd0, 32'd12345, 32'd678, 1'b1, 1'b0);
        runOp32(3'd0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0);

        // Reset while the iteration counter is at 10
        applyStimulus(3'd0, $urandom, $urandom);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mHi = 0; mLo = 0;
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        checkOutput("midrst_hi", 64'(hi), 64'd0);
        checkOutput("midrst_lo", 64'(lo), 64'd0);
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        checkOutput("midrst_no_done", 64'(sawDone), 64'd0);

        for (int i = 0; i < 40; i++) begin
            runOp32(3'($urandom_range(0, 7)), pickOperand(32), pickOperand(32),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);

        runOp8(3'd1, 8'h80, 8'h80);
        checkOutput("mult8_hi", 64'(hi8), 64'h40);
        checkOutput("mult8_lo", 64'(lo8), 64'h00);
        for (int i = 0; i < 25; i++) begin
            runOp8(3'($urandom_range(0, 7)), 8'(pickOperand(8)), 8'(pickOperand(8)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
